// File: rtl/bitser_pkg.sv
// rtl/bitser_pkg.sv - shared types and constants for the bit-order serializer
//
// Purpose: FSM state encoding and the default parallel word width used by
//          bit_order_serializer and its bench.
// Ports:   none (package).

package bitser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,  // shifter empty
    SHIFT = 1'b1   // shifter holds a word with bits still to send
  } state_t;

  localparam int DEFAULT_WIDTH = 64;

endpackage

// File: rtl/bit_reverse.sv
// rtl/bit_reverse.sv - combinational bit-order reversal of a parallel word
//
// Purpose: o_data[i] = i_data[WIDTH-1-i]; no state.
// Ports:   i_data  input  WIDTH  word to reverse
//          o_data  output WIDTH  reversed word

module bit_reverse #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_rev
    assign o_data[g] = i_data[WIDTH-1-g];
  end

endmodule

// File: rtl/bit_order_serializer.sv
// rtl/bit_order_serializer.sv - parallel-to-serial shifter with selectable bit order
//
// Purpose: accepts a WIDTH-bit word plus bit order and length on a
//          valid/ready load port and emits it one bit per handshake on a
//          valid/ready serial port. A one-entry holding register lets the
//          next word follow the last bit of the current one with no gap.
// Ports:   clock       input  1      rising-edge clock
//          reset       input  1      synchronous active-high reset
//          load_valid  input  1      upstream offers a word
//          load_ready  output 1      word can be accepted (holding register free)
//          data        input  WIDTH  parallel word
//          lsb_first   input  1      1: data[0] first, 0: data[WIDTH-1] first
//          len         input  LW     bits to send; 0 or >WIDTH means WIDTH
//          bit_out     output 1      serial bit
//          bit_valid   output 1      bit_out valid
//          bit_ready   input  1      downstream takes bit_out
//          done        output 1      last bit of a word transfers this cycle
//          busy        output 1      shifter or holding register occupied

module bit_order_serializer
  import bitser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LW    = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data,
  input  logic             lsb_first,
  input  logic [LW-1:0]    len,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             done,
  output logic             busy
);

  localparam logic [LW-1:0] FULL_LEN = LW'(WIDTH);
  localparam logic [LW-1:0] ONE      = LW'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic [LW-1:0]    r_cnt;
  logic [LW-1:0]    r_hold_cnt;
  logic             r_hold_full;

  logic [WIDTH-1:0] w_rev;
  logic [WIDTH-1:0] w_word;
  logic [LW-1:0]    w_len;
  logic             w_load_hs;
  logic             w_bit_hs;
  logic             w_last;

  // Words are normalised to LSB-first at load so the shifter only ever
  // emits bit 0 and shifts right.
  bit_reverse #(.WIDTH(WIDTH)) u_bit_reverse (
    .i_data(data),
    .o_data(w_rev)
  );

  assign w_word = lsb_first ? data : w_rev;
  assign w_len  = ((len == '0) || (len > FULL_LEN)) ? FULL_LEN : len;

  always_comb begin
    load_ready   = !r_hold_full;
    bit_valid    = (r_state == SHIFT);
    bit_out      = bit_valid & r_shift[0];
    w_load_hs    = load_valid && load_ready;
    w_bit_hs     = bit_valid && bit_ready;
    w_last       = w_bit_hs && (r_cnt == ONE);
    // A word cut short by reset never reports completion.
    done         = w_last && !reset;
    busy         = bit_valid || r_hold_full;
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_load_hs) w_state_next = SHIFT;
      SHIFT:   if (w_last && !r_hold_full && !w_load_hs) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift     <= '0;
      r_hold      <= '0;
      r_cnt       <= '0;
      r_hold_cnt  <= '0;
      r_hold_full <= 1'b0;
    end else if (r_state == IDLE) begin
      // Holding register is always empty in IDLE, so a new word goes
      // straight into the shifter.
      if (w_load_hs) begin
        r_shift <= w_word;
        r_cnt   <= w_len;
      end
    end else if (w_last) begin
      // Refill from hold first; a direct load is only possible when hold
      // is empty because load_ready is low while it is full.
      if (r_hold_full) begin
        r_shift     <= r_hold;
        r_cnt       <= r_hold_cnt;
        r_hold_full <= 1'b0;
      end else if (w_load_hs) begin
        r_shift <= w_word;
        r_cnt   <= w_len;
      end else begin
        r_shift <= r_shift >> 1;
        r_cnt   <= '0;
      end
    end else begin
      if (w_bit_hs) begin
        r_shift <= r_shift >> 1;
        r_cnt   <= r_cnt - ONE;
      end
      if (w_load_hs) begin
        r_hold      <= w_word;
        r_hold_cnt  <= w_len;
        r_hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bit_order_serializer.sv
// tb/tb_bit_order_serializer.sv - self-checking bench for bit_order_serializer

module tb_bit_order_serializer;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset     = 1'b1;
  logic        lsb_first = 1'b1;
  logic        bit_ready = 1'b0;
  logic        lv8       = 1'b0;
  logic [7:0]  data8     = '0;
  logic [3:0]  len8      = '0;
  logic        lv64      = 1'b0;
  logic [63:0] data64    = '0;
  logic [6:0]  len64     = '0;

  logic lr8, bo8, bv8, dn8, bz8;
  logic lr64, bo64, bv64, dn64, bz64;

  bit_order_serializer #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .load_valid(lv8), .load_ready(lr8),
    .data(data8), .lsb_first(lsb_first), .len(len8),
    .bit_out(bo8), .bit_valid(bv8), .bit_ready(bit_ready),
    .done(dn8), .busy(bz8)
  );

  bit_order_serializer #(.WIDTH(64)) dut64 (
    .clock(clock), .reset(reset), .load_valid(lv64), .load_ready(lr64),
    .data(data64), .lsb_first(lsb_first), .len(len64),
    .bit_out(bo64), .bit_valid(bv64), .bit_ready(bit_ready),
    .done(dn64), .busy(bz64)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          sel      = 0;

  // Reference model: the pending bit stream in send order, and the bits
  // still owed for each accepted word (at most one in flight plus one held).
  bit          exp_bits[$];
  int          word_left[$];

  logic [63:0] seen;
  int          nseen, ndone, nvalid;
  logic        last_bo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_seen();
    seen = '0; nseen = 0; ndone = 0; nvalid = 0;
  endtask

  task automatic step(input logic lv, input logic [63:0] d, input logic lsb,
                      input int l, input logic br, input logic rst);
    logic o_lr, o_bo, o_bv, o_dn, o_bz;
    logic e_valid, e_done;
    int   w, n;
    @(negedge clock);
    reset     = rst;
    lsb_first = lsb;
    bit_ready = br;
    if (sel == 0) begin
      lv8 = lv; data8 = d[7:0]; len8 = l[3:0]; lv64 = 1'b0;
    end else begin
      lv64 = lv; data64 = d; len64 = l[6:0]; lv8 = 1'b0;
    end
    #1;
    o_lr = sel ? lr64 : lr8;
    o_bo = sel ? bo64 : bo8;
    o_bv = sel ? bv64 : bv8;
    o_dn = sel ? dn64 : dn8;
    o_bz = sel ? bz64 : bz8;
    e_valid = (word_left.size() > 0);
    e_done  = e_valid && br && (word_left[0] == 1) && !rst;
    check("load_ready", 64'(o_lr), 64'(word_left.size() < 2));
    check("bit_valid",  64'(o_bv), 64'(e_valid));
    check("bit_out",    64'(o_bo), e_valid ? 64'(exp_bits[0]) : 64'd0);
    check("busy",       64'(o_bz), 64'(e_valid));
    check("done",       64'(o_dn), 64'(e_done));
    last_bo = o_bo;
    if (o_bv === 1'b1) nvalid++;
    if (o_dn === 1'b1) ndone++;
    if (o_bv === 1'b1 && br && nseen < 64) begin
      seen[nseen] = o_bo;
      nseen++;
    end
    w = sel ? 64 : 8;
    if (rst) begin
      exp_bits.delete();
      word_left.delete();
    end else begin
      logic ld;
      ld = lv && (word_left.size() < 2);
      if (e_valid && br) begin
        void'(exp_bits.pop_front());
        word_left[0] = word_left[0] - 1;
        if (word_left[0] == 0) void'(word_left.pop_front());
      end
      if (ld) begin
        n = (l == 0 || l > w) ? w : l;
        for (int i = 0; i < n; i++) exp_bits.push_back(d[lsb ? i : w - 1 - i]);
        word_left.push_back(n);
      end
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (word_left.size() > 0 && k < budget) begin
      step(1'b0, 64'd0, 1'b1, 0, 1'b1, 1'b0);
      k++;
    end
    check("drain_in_budget", 64'(word_left.size()), 64'd0);
  endtask

  task automatic random_run(input int cycles, input int maxlen, input int wbits);
    logic [63:0] d;
    for (int c = 0; c < cycles; c++) begin
      d = {$urandom, $urandom};
      if (wbits == 8) d = d & 64'hFF;
      step(1'($urandom % 2), d, 1'($urandom % 2), int'($urandom_range(0, maxlen)),
           1'($urandom % 4 != 0), 1'($urandom % 64 == 0));
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);

    // Reset state
    sel = 0;
    step(1'b0, 64'd0, 1'b1, 0, 1'b1, 1'b0);

    // B4 LSB-first: 0,0,1,0,1,1,0,1
    clear_seen();
    step(1'b1, 64'hB4, 1'b1, 8, 1'b1, 1'b0);
    drain(50);
    check("b4_lsb_bits", seen[7:0], 64'hB4);
    check("b4_lsb_count", 64'(nseen), 64'd8);
    check("b4_lsb_done", 64'(ndone), 64'd1);

    // B4 MSB-first: 1,0,1,1,0,1,0,0
    clear_seen();
    step(1'b1, 64'hB4, 1'b0, 8, 1'b1, 1'b0);
    drain(50);
    check("b4_msb_bits", seen[7:0], 64'h2D);
    check("b4_msb_done", 64'(ndone), 64'd1);

    // Back-to-back A5 (lsb) then 3C (msb) through the holding register
    clear_seen();
    step(1'b1, 64'hA5, 1'b1, 8, 1'b1, 1'b0);
    step(1'b1, 64'h3C, 1'b0, 8, 1'b1, 1'b0);
    drain(50);
    check("b2b_bits", seen[15:0], 64'h3CA5);
    check("b2b_valid_cycles", 64'(nvalid), 64'd16);
    check("b2b_done", 64'(ndone), 64'd2);

    // Stall after the 4th bit of B4
    clear_seen();
    step(1'b1, 64'hB4, 1'b1, 8, 1'b1, 1'b0);
    repeat (4) step(1'b0, 64'd0, 1'b1, 0, 1'b1, 1'b0);
    repeat (3) begin
      step(1'b0, 64'd0, 1'b1, 0, 1'b0, 1'b0);
      check("stall_bit", 64'(last_bo), 64'd1);
    end
    drain(50);
    check("stall_bits", seen[7:0], 64'hB4);
    check("stall_count", 64'(nseen), 64'd8);

    // Short length, MSB-first
    clear_seen();
    step(1'b1, 64'hE0, 1'b0, 3, 1'b1, 1'b0);
    drain(50);
    check("len3_bits", 64'(seen[2:0]), 64'd7);
    check("len3_count", 64'(nseen), 64'd3);
    check("len3_done", 64'(ndone), 64'd1);

    // len = 0 means full width
    clear_seen();
    step(1'b1, 64'h96, 1'b1, 0, 1'b1, 1'b0);
    drain(50);
    check("len0_count", 64'(nseen), 64'd8);
    check("len0_bits", seen[7:0], 64'h96);

    random_run(500, 15, 8);
    drain(100);

    // 64-bit: reset mid-word with a second word held
    sel = 1;
    step(1'b0, 64'd0, 1'b1, 0, 1'b1, 1'b1);
    clear_seen();
    step(1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 64, 1'b1, 1'b0);
    step(1'b1, 64'hFEDC_BA98_7654_3210, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 64'd0, 1'b1, 0, 1'b1, 1'b0);
    step(1'b1, 64'h1111_2222_3333_4444, 1'b1, 64, 1'b1, 1'b1);
    check("rst_no_done", 64'(ndone), 64'd0);
    step(1'b0, 64'd0, 1'b1, 0, 1'b1, 1'b0);
    check("rst_no_done_after", 64'(ndone), 64'd0);
    clear_seen();
    step(1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 8, 1'b1, 1'b0);
    drain(50);
    check("post_rst_bits", seen[7:0], 64'hEF);
    check("post_rst_count", 64'(nseen), 64'd8);

    random_run(600, 127, 64);
    drain(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
